// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton debouncer.
// Holds the per-channel FSM state encoding, the default timing constants
// for a 50 MHz clock, and the counter width helper.
package btn_pkg;

    // Per-channel qualification states.
    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_RISE_CHK = 2'd1,
        ST_HIGH     = 2'd2,
        ST_FALL_CHK = 2'd3
    } btn_state_e;

    // 1 kHz sample tick from 50 MHz, 20 ms of stability to accept a change.
    localparam int unsigned TICK_DIV_DEF     = 50000;
    localparam int unsigned STABLE_TICKS_DEF = 20;

    // Width of the stable-tick counter: clog2(n), never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: two-flop synchroniser, qualification FSM and
// stable-tick counter.
// Ports:
//   clk_i    system clock
//   rst_ni   synchronous active-low reset
//   btn_i    polarity-corrected asynchronous button (1 = pressed)
//   tick_i   shared one-cycle sample tick
//   level_o  debounced level, registered
//   busy_o   1 while a candidate change is being qualified, registered
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    input  logic tick_i,
    output logic level_o,
    output logic busy_o
);

    localparam int unsigned   CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          s1_q;
    logic          s2_q;
    btn_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          busy_q;
    logic          cnt_done_c;

    assign cnt_d      = cnt_q + CW'(1);
    assign cnt_done_c = (cnt_q == CNT_LAST);

    // Synchroniser plus FSM. The FSM only ever looks at s2_q. A tick arriving
    // in the entry cycle is ignored because the FSM is still in the stable
    // state then; a bounce takes precedence over a coincident tick.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
            case (state_q)
                ST_LOW: begin
                    if (s2_q) begin
                        state_q <= ST_RISE_CHK;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RISE_CHK: begin
                    if (!s2_q) begin
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (tick_i && cnt_done_c) begin
                        state_q <= ST_HIGH;
                        level_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (tick_i) begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_HIGH: begin
                    if (!s2_q) begin
                        state_q <= ST_FALL_CHK;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FALL_CHK: begin
                    if (s2_q) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (tick_i && cnt_done_c) begin
                        state_q <= ST_LOW;
                        level_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (tick_i) begin
                        cnt_q <= cnt_d;
                    end
                end
            endcase
        end
    end

    assign level_o = level_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel pushbutton conditioner: polarity correction, a free-running
// sample-tick prescaler shared by all channels, and one debounce channel
// per button.
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   btn_raw_i    asynchronous raw button pins
//   btn_level_o  debounced pressed level per button (1 = pressed), registered
//   btn_busy_o   per-button qualification-in-progress flag, registered
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned TICK_DIV      = TICK_DIV_DEF,
    parameter int unsigned STABLE_TICKS  = STABLE_TICKS_DEF,
    parameter bit          ACTIVE_LOW_IN = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_BTN-1:0] btn_raw_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_busy_o
);

    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic             tick_c;
    logic [N_BTN-1:0] btn_n_c;

    // Prescaler free-runs 0..TICK_DIV-1; never realigned by button activity.
    assign tick_c  = (presc_q == PRESC_LAST);
    assign presc_d = tick_c ? '0 : presc_q + PW'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Normalise to pressed-high before synchronising.
    assign btn_n_c = btn_raw_i ^ {N_BTN{ACTIVE_LOW_IN}};

    for (genvar g = 0; g < int'(N_BTN); g++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_ch (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .btn_i  (btn_n_c[g]),
            .tick_i (tick_c),
            .level_o(btn_level_o[g]),
            .busy_o (btn_busy_o[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: one pressed-high and one pressed-low instance fed
// with complementary pins, checked every cycle against a timestamp model.
module tb_btn_debounce;

    localparam int unsigned NB = 4;
    localparam int unsigned TD = 4;
    localparam int unsigned ST = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] raw;
    logic [NB-1:0] raw_al;
    logic [NB-1:0] lvl_h, busy_h, lvl_l, busy_l;

    always #5 clk = ~clk;

    assign raw_al = ~raw;

    btn_debounce #(
        .N_BTN(NB), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW_IN(1'b0)
    ) dut_h (
        .clk_i(clk), .rst_ni(rst_n), .btn_raw_i(raw),
        .btn_level_o(lvl_h), .btn_busy_o(busy_h)
    );

    btn_debounce #(
        .N_BTN(NB), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW_IN(1'b1)
    ) dut_l (
        .clk_i(clk), .rst_ni(rst_n), .btn_raw_i(raw_al),
        .btn_level_o(lvl_l), .btn_busy_o(busy_l)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int edges, input int lo, input int hi);
        total++;
        if (edges < lo || edges > hi) begin
            bad++;
            $display("FAIL %s: level changed at edge %0d, want %0d..%0d", name, edges, lo, hi);
        end
    endtask

    // Model: the pressed level seen by the FSM is the pin sampled two edges
    // earlier. A run starts on the first edge where that differs from the
    // accepted level; ticks are counted on the edges strictly after the start,
    // where edge with prescale count c is a tick iff (c+1) is a multiple of TD.
    logic [NB-1:0] m_lvl, m_busy, n_d1, n_d2;
    int            m_start[NB];
    int            pc;
    bit            valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_lvl  = '0;
            m_busy = '0;
            n_d1   = '0;
            n_d2   = '0;
            pc     = 0;
            valid  = 1'b1;
        end else begin
            for (int c = 0; c < int'(NB); c++) begin
                if (n_d2[c] == m_lvl[c]) begin
                    m_busy[c] = 1'b0;
                end else if (!m_busy[c]) begin
                    m_busy[c]  = 1'b1;
                    m_start[c] = pc;
                end else if ((pc + 1) / int'(TD) - (m_start[c] + 1) / int'(TD) >= int'(ST)) begin
                    m_lvl[c]  = ~m_lvl[c];
                    m_busy[c] = 1'b0;
                end
            end
            pc++;
            n_d2 = n_d1;
            n_d1 = raw;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (valid) begin
            check("level_hi", lvl_h,  m_lvl);
            check("busy_hi",  busy_h, m_busy);
            check("level_lo", lvl_l,  m_lvl);
            check("busy_lo",  busy_l, m_busy);
        end
    end

    // Counts edges from the last input change until (lvl_h & mask) == val.
    task automatic wait_vec(input string name, input logic [NB-1:0] mask,
                            input logic [NB-1:0] val, input int start);
        int e   = start;
        bit hit = 1'b0;
        while (e < 30 && !hit) begin
            @(posedge clk);
            e++;
            #1;
            if ((lvl_h & mask) == val) hit = 1'b1;
        end
        check_range(name, hit ? e : -1, 12, 15);
        @(negedge clk);
    endtask

    int hold[NB];
    bit seen;
    int first0;
    bit l3_at;

    initial begin
        rst_n = 1'b0;
        raw   = '1;

        // Reset with all buttons held.
        repeat (3) @(negedge clk);
        check("rst_level_hi", lvl_h,  4'b0000);
        check("rst_busy_hi",  busy_h, 4'b0000);
        check("rst_level_lo", lvl_l,  4'b0000);
        check("rst_busy_lo",  busy_l, 4'b0000);
        rst_n = 1'b1;
        wait_vec("held_through_rst", 4'b1111, 4'b1111, 0);
        raw = '0;
        wait_vec("release_all", 4'b1111, 4'b0000, 0);
        repeat (2) @(negedge clk);

        // Clean press and release on ch0.
        raw[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("busy0_edge2", busy_h & 4'b0001, 4'b0000);
        @(posedge clk);
        #1 check("busy0_edge3", busy_h & 4'b0001, 4'b0001);
        wait_vec("press0", 4'b0001, 4'b0001, 3);
        check("busy0_after_accept", busy_h & 4'b0001, 4'b0000);
        raw[0] = 1'b0;
        wait_vec("release0", 4'b0001, 4'b0000, 0);

        // Bounce on ch1 is rejected.
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) raw[1] = ~raw[1];
            @(posedge clk);
            #1 seen |= busy_h[1];
            @(negedge clk);
        end
        raw[1] = 1'b0;
        repeat (20) @(negedge clk);
        check("bounce1_level", lvl_h & 4'b0010, 4'b0000);
        check("bounce1_busy",  busy_h & 4'b0010, 4'b0000);
        check("bounce1_busy_pulsed", {3'b000, seen}, 4'b0001);

        // ch0 and ch3 pressed together while ch2 bounces.
        raw[0] = 1'b1;
        raw[3] = 1'b1;
        first0 = -1;
        l3_at  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i < 24 && i % 2 == 0) raw[2] = ~raw[2];
            @(posedge clk);
            #1;
            if (first0 < 0 && lvl_h[0]) begin
                first0 = i + 1;
                l3_at  = lvl_h[3];
            end
            @(negedge clk);
        end
        check_range("indep_ch0", first0, 12, 15);
        check("indep_ch3_same_edge", {3'b000, l3_at}, 4'b0001);
        check("indep_levels", lvl_h, 4'b1001);
        check("active_low_ch3", lvl_l, 4'b1001);
        raw = '0;
        wait_vec("release03", 4'b1001, 4'b0000, 0);
        repeat (2) @(negedge clk);

        // Reset while ch0 has counted two ticks.
        raw[0] = 1'b1;
        repeat (11) @(posedge clk);
        #1 check("midq_busy_before", busy_h & 4'b0001, 4'b0001);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midq_level_rst", lvl_h & 4'b0001, 4'b0000);
        check("midq_busy_rst",  busy_h & 4'b0001, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        wait_vec("midq_requalify", 4'b0001, 4'b0001, 0);
        raw = '0;
        wait_vec("midq_release", 4'b0001, 4'b0000, 0);

        // Random bounces, holds and occasional resets.
        for (int c = 0; c < int'(NB); c++) hold[c] = int'($urandom_range(1, 30));
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 399) != 0);
            for (int c = 0; c < int'(NB); c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    raw[c]  = ~raw[c];
                    hold[c] = ($urandom_range(0, 2) != 0) ? int'($urandom_range(1, 4))
                                                          : int'($urandom_range(10, 40));
                end
            end
        end

        @(negedge clk);
        rst_n = 1'b1;
        raw   = '0;
        repeat (40) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
